// File: rtl/iir_filter_mc.sv
// Multi-channel time-multiplexed 2nd-order IIR (direct form II), per-channel w1/w2 state.
// Latency 2 cycles from acceptance to vOut; one sample per cycle, any channel order.
// Backpressure: rdy drops for NCH cycles after reset or flush while state is swept to zero.
module iir_filter_mc #(
    parameter int NB  = 12,
    parameter int NCH = 4,
    parameter int SAT = 1,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vIn,
    input  logic [CW-1:0]     chIn,
    input  logic [NB-1:0]     dIn,
    input  logic [3*NB-1:0]   b,
    input  logic [2*NB-1:0]   a,
    input  logic              flush,
    output logic              rdy,
    output logic [NB-1:0]     dOut,
    output logic              vOut,
    output logic [CW-1:0]     chOut,
    output logic              ovf
);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    typedef struct packed {
        logic              vld;
        logic [CW-1:0]     ch;
        logic [NB-1:0]     w;
        logic [NB-1:0]     w1;
        logic [NB-1:0]     w2;
        logic              ovf_w;
        logic [3*NB-1:0]   b;
    } s1_t;

    // Full-precision product scaled back to Q1.(NB-1), floor rounding.
    function automatic logic signed [NB+2:0] mulq(input logic signed [NB-1:0] x,
                                                  input logic signed [NB-1:0] c);
        logic signed [2*NB-1:0] p;
        p = $signed({{NB{x[NB-1]}}, x}) * $signed({{NB{c[NB-1]}}, c});
        p = p >>> (NB - 1);
        return p[NB+2:0];
    endfunction

    // Returns {altered, value}: value fits when the top four bits are all sign copies.
    function automatic logic [NB:0] fit(input logic [NB+2:0] s);
        logic [NB-1:0] lo;
        logic          fits;
        lo   = s[NB-1:0];
        fits = (s[NB+2:NB-1] == {4{lo[NB-1]}});
        if (fits)
            return {1'b0, lo};
        if (SAT != 0)
            return {1'b1, s[NB+2], {(NB-1){~s[NB+2]}}};
        return {1'b1, lo};
    endfunction

    logic [0:0]          state;
    logic [CW-1:0]       cnt;
    logic [NB-1:0]       w1_mem [NCH];
    logic [NB-1:0]       w2_mem [NCH];
    logic                acc;
    logic [NB-1:0]       cur_w1;
    logic [NB-1:0]       cur_w2;
    logic [NB+2:0]       w_sum;
    logic [NB:0]         w_fit;
    logic [NB+2:0]       y_sum;
    logic [NB:0]         y_fit;
    s1_t                 s1;

    assign rdy    = (state == RUN);
    assign acc    = vIn & rdy;
    assign cur_w1 = w1_mem[chIn];
    assign cur_w2 = w2_mem[chIn];

    assign w_sum = {{3{dIn[NB-1]}}, dIn}
                 - mulq(a[NB-1:0], cur_w1)
                 - mulq(a[2*NB-1:NB], cur_w2);
    assign w_fit = fit(w_sum);

    assign y_sum = mulq(s1.b[NB-1:0], s1.w)
                 + mulq(s1.b[2*NB-1:NB], s1.w1)
                 + mulq(s1.b[3*NB-1:2*NB], s1.w2);
    assign y_fit = fit(y_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            if (cnt == CW'(NCH - 1)) begin
                state <= RUN;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (flush) begin
            state <= CLEAR;
            cnt   <= '0;
        end
    end

    // State is written at the end of stage 1, so a same-channel sample next cycle sees it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                w1_mem[cnt] <= '0;
                w2_mem[cnt] <= '0;
            end else if (acc) begin
                w2_mem[chIn] <= cur_w1;
                w1_mem[chIn] <= w_fit[NB-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            dOut  <= '0;
            vOut  <= 1'b0;
            chOut <= '0;
            ovf   <= 1'b0;
        end else begin
            s1.vld <= acc;
            if (acc) begin
                s1.ch    <= chIn;
                s1.w     <= w_fit[NB-1:0];
                s1.w1    <= cur_w1;
                s1.w2    <= cur_w2;
                s1.ovf_w <= w_fit[NB];
                s1.b     <= b;
            end
            vOut <= s1.vld;
            if (s1.vld) begin
                dOut  <= y_fit[NB-1:0];
                chOut <= s1.ch;
                ovf   <= s1.ovf_w | y_fit[NB];
            end
        end
    end

endmodule

// File: tb/tb_iir_filter_mc.sv
// Bench for iir_filter_mc: saturating and wrapping instances share stimulus, checked
// against an integer reference model plus hand-computed values.
module tb_iir_filter_mc;

    localparam int NB  = 12;
    localparam int NCH = 4;
    localparam int CW  = 2;

    typedef struct packed {
        logic            vs;
        logic            vw;
        logic [CW-1:0]   cs;
        logic [CW-1:0]   cw;
        logic [NB-1:0]   ds;
        logic            os;
        logic [NB-1:0]   dw;
        logic            ow;
        logic [31:0]     cyc;
    } out_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vIn = 1'b0;
    logic              flush = 1'b0;
    logic [CW-1:0]     chIn = '0;
    logic [NB-1:0]     dIn = '0;
    logic [3*NB-1:0]   b = '0;
    logic [2*NB-1:0]   a = '0;
    logic              rdy_s, vOut_s, ovf_s, rdy_w, vOut_w, ovf_w;
    logic [NB-1:0]     dOut_s, dOut_w;
    logic [CW-1:0]     chOut_s, chOut_w;

    logic [31:0]       cyc = '0;
    out_t              exp_q[$];
    out_t              obs_q[$];
    out_t              mo;
    int                mw1 [2][NCH];
    int                mw2 [2][NCH];
    int                clear_left = 0;
    int                checks = 0;
    int                failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iir_filter_mc #(.NB(NB), .NCH(NCH), .SAT(1)) dut_s (
        .clk(clk), .rst(rst), .vIn(vIn), .chIn(chIn), .dIn(dIn), .b(b), .a(a),
        .flush(flush), .rdy(rdy_s), .dOut(dOut_s), .vOut(vOut_s), .chOut(chOut_s), .ovf(ovf_s)
    );

    iir_filter_mc #(.NB(NB), .NCH(NCH), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .vIn(vIn), .chIn(chIn), .dIn(dIn), .b(b), .a(a),
        .flush(flush), .rdy(rdy_w), .dOut(dOut_w), .vOut(vOut_w), .chOut(chOut_w), .ovf(ovf_w)
    );

    always @(negedge clk) begin
        if (vOut_s === 1'b1 || vOut_w === 1'b1) begin
            mo.vs  = vOut_s;
            mo.vw  = vOut_w;
            mo.cs  = chOut_s;
            mo.cw  = chOut_w;
            mo.ds  = dOut_s;
            mo.os  = ovf_s;
            mo.dw  = dOut_w;
            mo.ow  = ovf_w;
            mo.cyc = cyc;
            obs_q.push_back(mo);
        end
    end

    function automatic int sx(input logic [NB-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int mul(input int p, input int q);
        return (p * q) >>> (NB - 1);
    endfunction

    // m = 0 saturates, m = 1 keeps the low NB bits.
    function automatic int fitm(input int s, input int m, output bit o);
        int lim;
        lim = 1 << (NB - 1);
        o = (s < -lim) || (s >= lim);
        if (!o) return s;
        if (m == 0) return (s < 0) ? -lim : lim - 1;
        return (((s + lim) % (2 * lim)) + 2 * lim) % (2 * lim) - lim;
    endfunction

    function automatic void zero_model();
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < NCH; c++) begin
                mw1[m][c] = 0;
                mw2[m][c] = 0;
            end
    endfunction

    // Called right after a falling edge; drives one cycle and advances the model.
    task automatic step(input bit v, input int ch, input int d, input bit fl);
        out_t e;
        int   w [2];
        int   y [2];
        bit   ow [2];
        bit   oy [2];
        vIn   = v;
        chIn  = ch[CW-1:0];
        dIn   = d[NB-1:0];
        flush = fl;
        if (v && clear_left == 0) begin
            for (int m = 0; m < 2; m++) begin
                w[m] = fitm(sx(dIn) - mul(sx(a[NB-1:0]), mw1[m][ch])
                            - mul(sx(a[2*NB-1:NB]), mw2[m][ch]), m, ow[m]);
                y[m] = fitm(mul(sx(b[NB-1:0]), w[m]) + mul(sx(b[2*NB-1:NB]), mw1[m][ch])
                            + mul(sx(b[3*NB-1:2*NB]), mw2[m][ch]), m, oy[m]);
                mw2[m][ch] = mw1[m][ch];
                mw1[m][ch] = w[m];
            end
            e.vs  = 1'b1;
            e.vw  = 1'b1;
            e.cs  = ch[CW-1:0];
            e.cw  = ch[CW-1:0];
            e.ds  = y[0][NB-1:0];
            e.os  = ow[0] | oy[0];
            e.dw  = y[1][NB-1:0];
            e.ow  = ow[1] | oy[1];
            e.cyc = cyc + 2;
            exp_q.push_back(e);
        end
        if (clear_left > 0) begin
            clear_left--;
        end else if (fl) begin
            zero_model();
            clear_left = NCH;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0);
    endtask

    task automatic do_flush();
        step(0, 0, 0, 1);
        idle(NCH);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({vOut_s, vOut_w, dOut_s, dOut_w, ovf_s, ovf_w, rdy_s, rdy_w} !== '0) begin
                failures++;
                $display("FAIL reset_hold: vOut=%b%b dOut=%h/%h ovf=%b%b rdy=%b%b, want all zero",
                         vOut_s, vOut_w, dOut_s, dOut_w, ovf_s, ovf_w, rdy_s, rdy_w);
            end
        end
        rst = 1'b0;
        zero_model();
        clear_left = NCH;
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (rdy_s !== 1'b0 || rdy_w !== 1'b0 || vOut_s !== 1'b0 || dOut_s !== '0) begin
                failures++;
                $display("FAIL reset_clear[%0d]: rdy=%b%b vOut=%b dOut=%h, want rdy=0 vOut=0 dOut=0",
                         i, rdy_s, rdy_w, vOut_s, dOut_s);
            end
            idle(1);
        end
        checks++;
        if (rdy_s !== 1'b1 || rdy_w !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: rdy=%b%b, want 11", rdy_s, rdy_w);
        end
    endtask

    task automatic test_fir();
        logic [NB-1:0] want [4];
        want = '{12'h200, 12'h200, 12'h200, 12'h000};
        do_flush();
        b = {3{12'h400}};
        a = '0;
        step(1, 0, 'h400, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].ds !== want[i] || obs_q[i].dw !== want[i] || obs_q[i].cs !== 0 || obs_q[i].os !== 0) begin
                failures++;
                $display("FAIL fir[%0d]: dOut=%h/%h ch=%0d ovf=%b, want %h ch=0 ovf=0",
                         i, obs_q[i].ds, obs_q[i].dw, obs_q[i].cs, obs_q[i].os, want[i]);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL fir_count: got %0d outputs, want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL fir_model[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_feedback();
        logic [NB-1:0] want [3];
        want = '{12'h200, 12'h100, 12'h080};
        do_flush();
        b = {12'h000, 12'h000, 12'h400};
        a = {12'h000, 12'hC00};
        step(1, 0, 'h400, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].ds !== want[i] || obs_q[i].dw !== want[i]) begin
                failures++;
                $display("FAIL feedback[%0d]: dOut=%h/%h, want %h", i, obs_q[i].ds, obs_q[i].dw, want[i]);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL feedback_count: got %0d outputs, want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL feedback_model[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_isolation();
        logic [NB-1:0] want [8];
        want = '{12'h200, 12'h000, 12'h200, 12'h000, 12'h200, 12'h000, 12'h000, 12'h000};
        do_flush();
        b = {3{12'h400}};
        a = '0;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, (i == 0) ? 'h400 : 0, 0);
            step(1, 1, 0, 0);
        end
        idle(3);
        for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].ds !== want[i] || obs_q[i].cs !== CW'(i % 2)) begin
                failures++;
                $display("FAIL isolation[%0d]: dOut=%h ch=%0d, want %h ch=%0d",
                         i, obs_q[i].ds, obs_q[i].cs, want[i], i % 2);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL isolation_count: got %0d outputs, want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL isolation_model[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_overflow();
        logic [NB-1:0] want_s [2];
        logic [NB-1:0] want_w [2];
        logic          want_o [2];
        want_s = '{12'h7FE, 12'h7FF};
        want_w = '{12'h7FE, 12'hFFC};
        want_o = '{1'b0, 1'b1};
        do_flush();
        b = {12'h000, 12'h7FF, 12'h7FF};
        a = '0;
        step(1, 0, 'h7FF, 0);
        step(1, 0, 'h7FF, 0);
        idle(3);
        for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].ds !== want_s[i] || obs_q[i].os !== want_o[i] ||
                obs_q[i].dw !== want_w[i] || obs_q[i].ow !== want_o[i]) begin
                failures++;
                $display("FAIL overflow[%0d]: sat %h ovf=%b wrap %h ovf=%b, want sat %h wrap %h ovf=%b",
                         i, obs_q[i].ds, obs_q[i].os, obs_q[i].dw, obs_q[i].ow,
                         want_s[i], want_w[i], want_o[i]);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL overflow_count: got %0d outputs, want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL overflow_model[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_flush();
        logic [NB-1:0] want [5];
        want = '{12'h200, 12'h100, 12'h200, 12'h100, 12'h080};
        do_flush();
        b = {12'h000, 12'h000, 12'h400};
        a = {12'h000, 12'hC00};
        step(1, 0, 'h400, 0);
        step(1, 0, 0, 1);
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (rdy_s !== 1'b0 || rdy_w !== 1'b0) begin
                failures++;
                $display("FAIL flush_busy[%0d]: rdy=%b%b, want 00", i, rdy_s, rdy_w);
            end
            step(1, 0, 'h123, 0);
        end
        checks++;
        if (rdy_s !== 1'b1 || rdy_w !== 1'b1) begin
            failures++;
            $display("FAIL flush_ready: rdy=%b%b, want 11", rdy_s, rdy_w);
        end
        step(1, 0, 'h400, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].ds !== want[i]) begin
                failures++;
                $display("FAIL flush_seq[%0d]: dOut=%h, want %h", i, obs_q[i].ds, want[i]);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL flush_count: got %0d outputs, want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL flush_model[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        b = {3{12'h400}};
        a = '0;
        step(1, 2, 'h400, 0);
        rst = 1'b1;
        vIn = 1'b0;
        @(negedge clk);
        checks++;
        if ({vOut_s, vOut_w, dOut_s, dOut_w, chOut_s, chOut_w, ovf_s, ovf_w, rdy_s} !== '0) begin
            failures++;
            $display("FAIL reset_mid: vOut=%b%b dOut=%h/%h ch=%0d/%0d ovf=%b%b rdy=%b, want all zero",
                     vOut_s, vOut_w, dOut_s, dOut_w, chOut_s, chOut_w, ovf_s, ovf_w, rdy_s);
        end
        rst = 1'b0;
        exp_q.delete();
        zero_model();
        clear_left = NCH;
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if (rdy_s !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_busy[%0d]: rdy=%b, want 0", i, rdy_s);
            end
            idle(1);
        end
        idle(2);
        checks++;
        if (obs_q.size() != 0 || rdy_s !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_drop: %0d outputs rdy=%b, want 0 outputs rdy=1", obs_q.size(), rdy_s);
        end
        obs_q.delete();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            b = {$urandom, $urandom};
            a = $urandom;
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, NCH - 1)),
                 int'($urandom_range(0, 4095)), $urandom_range(0, 39) == 0);
        end
        idle(3);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count: got %0d outputs, want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL random_model[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_fir();
        test_feedback();
        test_isolation();
        test_overflow();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
